block_lock_descr_rx_32b: RTL



---
 rtl/rx_pcs_pkg.sv | 29 ++
 rtl/descrambler_58_32b.sv | 31 +++
 rtl/block_lock_descr_rx_32b.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rx_pcs_pkg.sv
// ============================================================================
// rx_pcs_pkg : shared sync-header codes, lock defaults, FSM states, block type
// Rev 1.0
// ============================================================================
`default_nettype none

package rx_pcs_pkg;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   localparam int DEF_LOCK_CNT  = 64;
   localparam int DEF_INVLD_MAX = 16;

   typedef enum logic [1:0] {
      LOCK_INIT = 2'd0,
      TEST_SH   = 2'd1,
      SLIP_WAIT = 2'd2,
      LOCKED    = 2'd3
   } lock_state_t;

   typedef struct packed {
      logic [1:0]  hdr;
      logic [63:0] data;
   } blk66_t;

endpackage

`default_nettype wire

// File: rtl/descrambler_58_32b.sv
// ============================================================================
// descrambler_58_32b : self-synchronous x^58+x^39+1 descrambler, 32 bits/clk
// Rev 1.0
// ============================================================================
`default_nettype none

module descrambler_58_32b (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   // r_hist[0] is the oldest received scrambled bit
   logic [57:0] r_hist;
   logic [89:0] w_x;

   assign w_x  = {din, r_hist};
   assign dout = din ^ w_x[50:19] ^ w_x[31:0];

   always_ff @(posedge clk) begin
      if (!rst)
         r_hist <= '0;
      else if (en)
         r_hist <= w_x[89:32];
   end

endmodule

`default_nettype wire

// File: rtl/block_lock_descr_rx_32b.sv
// ============================================================================
// block_lock_descr_rx_32b : half-block pairing, sync-header block lock FSM,
// descrambling and 66-bit block output for a 32-bit receive PCS datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module block_lock_descr_rx_32b #(
   parameter int LOCK_CNT  = rx_pcs_pkg::DEF_LOCK_CNT,
   parameter int INVLD_MAX = rx_pcs_pkg::DEF_INVLD_MAX,
   parameter int SLIP_WAIT = 34,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          din,
   input  logic [1:0]           ctrl,
   input  logic                 din_en,
   input  logic                 even,
   output logic [63:0]          blk_data,
   output logic [1:0]           blk_hdr,
   output logic                 blk_valid,
   output logic                 block_lock,
   output logic                 slip,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   import rx_pcs_pkg::*;

   localparam int c_wait_w = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);

   logic [31:0]         w_dsc;
   logic [31:0]         r_lo;
   logic [1:0]          r_hdr;
   logic                r_have_lo;
   logic                w_blk_done;
   logic                w_sh_valid;

   lock_state_t         r_state, w_state_nxt;
   logic [6:0]          r_sh_cnt, w_sh_cnt_nxt, w_sh_inc;
   logic [4:0]          r_invld_cnt, w_invld_cnt_nxt, w_invld_inc;
   logic [c_wait_w-1:0] r_wait_cnt, w_wait_cnt_nxt, w_wait_inc;
   logic                w_slip_nxt;
   logic                w_err_inc;
   blk66_t              r_blk;

   descrambler_58_32b u_descr (
      .clk  (clk),
      .rst  (rst),
      .en   (din_en),
      .din  (din),
      .dout (w_dsc)
   );

   assign w_blk_done  = din_en & ~even & r_have_lo;
   assign w_sh_valid  = (r_hdr == SH_DATA) | (r_hdr == SH_CTRL);
   assign w_sh_inc    = r_sh_cnt + 7'd1;
   assign w_invld_inc = r_invld_cnt + 5'd1;
   assign w_wait_inc  = r_wait_cnt + c_wait_w'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_sh_cnt_nxt    = r_sh_cnt;
      w_invld_cnt_nxt = r_invld_cnt;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_slip_nxt      = 1'b0;
      w_err_inc       = 1'b0;
      case (r_state)
         LOCK_INIT: begin
            w_sh_cnt_nxt    = '0;
            w_invld_cnt_nxt = '0;
            w_wait_cnt_nxt  = '0;
            w_state_nxt     = TEST_SH;
         end
         TEST_SH: begin
            if (w_blk_done) begin
               if (w_sh_valid) begin
                  w_sh_cnt_nxt = w_sh_inc;
                  if (w_sh_inc == 7'(LOCK_CNT)) begin
                     w_sh_cnt_nxt    = '0;
                     w_invld_cnt_nxt = '0;
                     w_state_nxt     = LOCKED;
                  end
               end else begin
                  w_slip_nxt      = 1'b1;
                  w_sh_cnt_nxt    = '0;
                  w_invld_cnt_nxt = '0;
                  w_wait_cnt_nxt  = '0;
                  w_state_nxt     = rx_pcs_pkg::SLIP_WAIT;
               end
            end
         end
         rx_pcs_pkg::SLIP_WAIT: begin
            if (w_blk_done) begin
               w_wait_cnt_nxt = w_wait_inc;
               if (w_wait_inc == c_wait_w'(SLIP_WAIT)) begin
                  w_wait_cnt_nxt = '0;
                  w_sh_cnt_nxt   = '0;
                  w_state_nxt    = TEST_SH;
               end
            end
         end
         LOCKED: begin
            if (w_blk_done) begin
               w_sh_cnt_nxt = w_sh_inc;
               if (!w_sh_valid) begin
                  w_err_inc       = 1'b1;
                  w_invld_cnt_nxt = w_invld_inc;
               end
               // The invalid threshold takes priority over the window wrap
               if (!w_sh_valid && (w_invld_inc == 5'(INVLD_MAX))) begin
                  w_slip_nxt      = 1'b1;
                  w_sh_cnt_nxt    = '0;
                  w_invld_cnt_nxt = '0;
                  w_wait_cnt_nxt  = '0;
                  w_state_nxt     = rx_pcs_pkg::SLIP_WAIT;
               end else if (w_sh_inc == 7'(LOCK_CNT)) begin
                  w_sh_cnt_nxt    = '0;
                  w_invld_cnt_nxt = '0;
               end
            end
         end
         default: w_state_nxt = LOCK_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= LOCK_INIT;
         r_sh_cnt    <= '0;
         r_invld_cnt <= '0;
         r_wait_cnt  <= '0;
         slip        <= 1'b0;
         block_lock  <= 1'b0;
         err_cnt     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sh_cnt    <= w_sh_cnt_nxt;
         r_invld_cnt <= w_invld_cnt_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         slip        <= w_slip_nxt;
         block_lock  <= (w_state_nxt == LOCKED);
         if (w_err_inc && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lo      <= '0;
         r_hdr     <= '0;
         r_have_lo <= 1'b0;
         r_blk     <= '0;
         blk_valid <= 1'b0;
      end else begin
         blk_valid <= w_blk_done;
         if (din_en) begin
            if (even) begin
               r_lo      <= w_dsc;
               r_hdr     <= ctrl;
               r_have_lo <= 1'b1;
            end else begin
               r_have_lo <= 1'b0;
            end
         end
         if (w_blk_done) begin
            r_blk.hdr  <= r_hdr;
            r_blk.data <= {w_dsc, r_lo};
         end
      end
   end

   assign blk_data = r_blk.data;
   assign blk_hdr  = r_blk.hdr;

endmodule

`default_nettype wire
